mult_seq: RTL
=============

# mult_seq

Parametrised, iterative multiplier with operand-parity checking and a req/ack/result_rdy handshake. It is the next generation of the team's 16×16 parity-protected multiplier. It adds operand width as a parameter and a per-transaction signed/unsigned mode, and computes with a one-bit-per-cycle shift-add engine instead of a single-cycle product. The existing `send_data`-style BFM drives it unchanged. It sits behind that BFM in the lab testbench and is the DUT for the lab's coverage and scoreboard work.

## Interface
- `WIDTH`, 16, operand width in bits (≥2); result width is 2·WIDTH.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: operand request, held high by master until `ack`.
- `arg_a` in WIDTH: operand A.
- `arg_a_parity` in 1: even-parity bit of A; valid when `arg_a_parity == ^arg_a`.
- `arg_b` in WIDTH: operand B.
- `arg_b_parity` in 1: even-parity bit of B.
- `signed_mode` in 1: 1 = two's-complement operands and result; 0 = unsigned.
- `ack` out 1: one-cycle pulse; operands captured.
- `result` out 2·WIDTH: product, or 0 on a parity error.
- `result_parity` out 1: `^result`.
- `result_rdy` out 1: one-cycle pulse; result fields valid.
- `arg_parity_error` out 1: set when either operand parity mismatches.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, `req`=1 at an edge:
  - capture `arg_a`, `arg_b`, `signed_mode`, both parity checks;
  - assert `ack` for the following cycle;
  - on parity OK, load the BUSY counter with WIDTH;
  - on parity error, load the BUSY counter with 1.
- BUSY: one shift-add step per cycle on operand magnitudes.
  - In signed mode, magnitudes are `|a|` and `|b|`, and the product is negated if the signs differ.
  - In unsigned mode the operands are used directly.
  - When the counter expires, write `result`, `result_parity` and `arg_parity_error`, then go to DONE.
- DONE: `result_rdy`=1 for exactly one cycle, then IDLE.
- Parity-error path: `result`=0, `result_parity`=0, `arg_parity_error`=1.
- Output holding: `result`, `result_parity` and `arg_parity_error` hold their values until the next completion or reset. `ack` and `result_rdy` are pulses only.
- `req` is ignored in BUSY and DONE. If `req` is still high on return to IDLE, a new transaction starts; back-to-back operation is legal.
- Signed corner case: −2^(WIDTH−1) × −2^(WIDTH−1) = 2^(2·WIDTH−2). This is representable and must be exact; the magnitude path must be WIDTH bits unsigned, not WIDTH−1.
- Unsigned corner case: (2^WIDTH−1)² must be exact.

## Timing
- Reset: `rst`=1 at any edge forces IDLE with all outputs 0 (`ack`, `result_rdy`, `result`, `result_parity`, `arg_parity_error`).
- Reset mid-BUSY aborts the operation: no `result_rdy`, no `ack`.
- Let edge E0 be the capture edge. `ack` is high in the cycle after E0.
- Normal latency: `result_rdy` is high in the cycle after edge E0+WIDTH+1, i.e. WIDTH+1 cycles after the `ack` cycle.
- Parity-error latency: `result_rdy` is high 2 cycles after the `ack` cycle.
- Minimum spacing between captures is WIDTH+3 edges (normal) or 4 edges (error).
- `result` fields become valid in the same cycle that `result_rdy` rises. They are never updated while `result_rdy`=0, except by reset.

## Structure
- Package `mult_pkg`:
  - typedef `state_t` {IDLE, BUSY, DONE};
  - function `parity_even(logic [N-1:0])`, usable by the RTL and the scoreboard.
- Sub-module `mult_seq_core`: unsigned WIDTH×WIDTH shift-add engine with start/done, accumulator and counter.
- The top level holds the FSM, parity checks, abs/negate logic and output registers.

## Test plan (WIDTH=16)
- Signed: A=3 (par 0), B=−5=0xFFFB (par 1), `signed_mode`=1.
  - Expect `result`=0xFFFFFFF1, `result_parity`=1, `arg_parity_error`=0.
  - Expect `result_rdy` 17 cycles after `ack`.
- Signed corner: A=B=0x8000 (par 1 each), `signed_mode`=1 → `result`=0x40000000, `result_parity`=1.
- Unsigned: A=B=0xFFFF (par 0), `signed_mode`=0 → `result`=0xFFFE0001, `result_parity`=0.
- Parity error: A=3 with `arg_a_parity`=1, B=2 → `arg_parity_error`=1, `result`=0, `result_parity`=0, `result_rdy` 2 cycles after `ack`.
- Reset mid-op: `rst`=1 for one edge, 5 cycles after `ack`.
  - Expect all outputs 0 and no `result_rdy`.
  - A following 7×6 op returns 42 (0x0000002A, parity 1).
- Back-to-back: `req` held high for two operations (2×3, then −1×−1) → two `ack` pulses and two `result_rdy` pulses with results 6 and 1.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential parity-protected multiplier.
package mult_pkg;

   // Controller states of the multiplier.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Widest vector parity_even accepts; narrower vectors are zero-extended,
   // which leaves their parity unchanged. Covers WIDTH up to 64.
   localparam int PAR_MAX_W = 128;

   // Even-parity bit of a vector: the bit that makes the total count of ones even.
   function automatic logic parity_even(input logic [PAR_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/mult_seq_core.sv
// Unsigned WIDTH x WIDTH shift-add engine: one multiplier bit per cycle.
// A start pulse loads the operands and the step counter; done is high
// whenever the counter is at zero, and product is then final.
module mult_seq_core #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               short_run,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Next-state of the datapath: load on start, otherwise one shift-add step per cycle while counting.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (start) begin
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, op_a};
         mplier_d = op_b;
         // A short run lets the controller spend a single cycle here on operands it will discard.
         cnt_d    = short_run ? CNT_W'(1) : CNT_W'(WIDTH);
      end else if (cnt_q != '0) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CNT_W'(1);
      end
   end

   // Step counter: the only core state that must be cleared by reset, so an aborted run stops at once.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      // NOTE: no reset here on purpose; start always reloads these before product is consumed.
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
   end

   assign done    = (cnt_q == '0);
   assign product = acc_q;

endmodule

// File: rtl/mult_seq.sv
// Iterative parity-protected multiplier with a req/ack/result_rdy handshake.
// Holds the controller, the operand parity checks, the sign handling around
// the unsigned core, and the registered result fields.
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic [WIDTH-1:0]   arg_a,
   input  logic               arg_a_parity,
   input  logic [WIDTH-1:0]   arg_b,
   input  logic               arg_b_parity,
   input  logic               signed_mode,
   output logic               ack,
   output logic [2*WIDTH-1:0] result,
   output logic               result_parity,
   output logic               result_rdy,
   output logic               arg_parity_error
);

   state_t             state_q, state_d;
   logic               ack_q, ack_d;
   logic               rdy_q, rdy_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               res_par_q, res_par_d;
   logic               perr_q, perr_d;
   logic               neg_q, neg_d;
   logic               err_q, err_d;

   logic               capture;
   logic               a_par_ok, b_par_ok;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               core_done;
   logic [2*WIDTH-1:0] core_product;
   logic [2*WIDTH-1:0] signed_prod;

   assign capture  = (state_q == IDLE) && req;
   assign a_par_ok = (parity_even(PAR_MAX_W'(arg_a)) == arg_a_parity);
   assign b_par_ok = (parity_even(PAR_MAX_W'(arg_b)) == arg_b_parity);

   // Magnitudes stay WIDTH bits unsigned so the most negative operand maps to 2^(WIDTH-1) exactly.
   assign mag_a = (signed_mode && arg_a[WIDTH-1]) ? -arg_a : arg_a;
   assign mag_b = (signed_mode && arg_b[WIDTH-1]) ? -arg_b : arg_b;

   // The magnitude product is negated back when the operand signs differed.
   assign signed_prod = neg_q ? -core_product : core_product;

   mult_seq_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .start     (capture),
      .short_run (!(a_par_ok && b_par_ok)),
      .op_a      (mag_a),
      .op_b      (mag_b),
      .done      (core_done),
      .product   (core_product)
   );

   // Controller next-state: capture in IDLE, finish when the core's counter expires, pulse ready in DONE.
   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      rdy_d     = 1'b0;
      result_d  = result_q;
      res_par_d = res_par_q;
      perr_d    = perr_q;
      neg_d     = neg_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               ack_d   = 1'b1;
               neg_d   = signed_mode && (arg_a[WIDTH-1] ^ arg_b[WIDTH-1]);
               err_d   = !(a_par_ok && b_par_ok);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (core_done) begin
               rdy_d   = 1'b1;
               state_d = DONE;
               if (err_q) begin
                  result_d  = '0;
                  res_par_d = 1'b0;
                  perr_d    = 1'b1;
               end else begin
                  result_d  = signed_prod;
                  res_par_d = parity_even(PAR_MAX_W'(signed_prod));
                  perr_d    = 1'b0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller state and registered outputs; reset aborts any run and clears every output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         rdy_q     <= 1'b0;
         result_q  <= '0;
         res_par_q <= 1'b0;
         perr_q    <= 1'b0;
         neg_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         rdy_q     <= rdy_d;
         result_q  <= result_d;
         res_par_q <= res_par_d;
         perr_q    <= perr_d;
         neg_q     <= neg_d;
         err_q     <= err_d;
      end
   end

   assign ack              = ack_q;
   assign result_rdy       = rdy_q;
   assign result           = result_q;
   assign result_parity    = res_par_q;
   assign arg_parity_error = perr_q;

endmodule
